// File: rtl/stream_rescale_pkg.sv
// rtl/stream_rescale_pkg.sv - shared types and round-robin helper for the rescaler arbiter
//
// Contents:
//   arb_state_t  arbiter FSM encoding (idle / packet granted)
//   RR_MAX_SRC   widest request vector rr_pick accepts
//   rr_pick      first set request at or after ptr, wrapping at n_src
package stream_rescale_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MAX_SRC = 32;

    // Searches ptr, ptr+1, ... wrapping at n_src. The loop is bounded by a
    // constant so it unrolls in synthesis; slots at or beyond n_src are skipped.
    // Returns ptr when nothing is requesting (callers gate on |req).
    function automatic int rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                   input int                    ptr,
                                   input int                    n_src);
        int   pick;
        int   idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_SRC; k++) begin
            if (k < n_src) begin
                idx = ptr + k;
                if (idx >= n_src) begin
                    idx = idx - n_src;
                end
                if (!found && req[idx[4:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - one-deep registered stream slice with data/keep/last/user
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_s_tdata/tkeep/tlast/tuser      upstream beat
//   i_s_tvalid, o_s_tready           upstream handshake
//   o_m_tdata/tkeep/tlast/tuser      registered beat
//   o_m_tvalid, i_m_tready           downstream handshake
module stream_reg_slice #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_s_tdata,
    input  logic [KEEP_W-1:0] i_s_tkeep,
    input  logic              i_s_tlast,
    input  logic [USER_W-1:0] i_s_tuser,
    input  logic              i_s_tvalid,
    output logic              o_s_tready,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic [KEEP_W-1:0] o_m_tkeep,
    output logic              o_m_tlast,
    output logic [USER_W-1:0] o_m_tuser,
    output logic              o_m_tvalid,
    input  logic              i_m_tready
);

    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;
    logic [USER_W-1:0] r_user;
    logic              r_valid;
    logic              w_load;

    // The register can take a beat when empty or when its current beat
    // leaves this cycle, so back-to-back streaming has no bubble.
    assign o_s_tready = !r_valid || i_m_tready;
    assign w_load     = i_s_tvalid && o_s_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_user  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= i_s_tdata;
            r_keep  <= i_s_tkeep;
            r_last  <= i_s_tlast;
            r_user  <= i_s_tuser;
            r_valid <= 1'b1;
        end else if (i_m_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_m_tdata  = r_data;
    assign o_m_tkeep  = r_keep;
    assign o_m_tlast  = r_last;
    assign o_m_tuser  = r_user;
    assign o_m_tvalid = r_valid;

endmodule

// File: rtl/stream_rescale_arbiter.sv
// rtl/stream_rescale_arbiter.sv - packet-level round-robin arbiter feeding one stream_rescale slave port
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   s_data_in      per-source lane data          s_keep_in   per-source lane mask
//   s_last_in      per-source end of packet      s_valid_in  per-source beat valid
//   s_ready_out    per-source beat accept
//   m_data_out/m_keep_out/m_last_out/m_valid_out  registered beat to rescaler
//   m_ready_in     rescaler ready
//   m_src_out      source owning the beat in the output register
//   busy_out       a packet grant is open
module stream_rescale_arbiter
    import stream_rescale_pkg::*;
#(
    parameter  int N_SRC        = 4,
    parameter  int T_DATA_WIDTH = 8,
    parameter  int KEEP_WIDTH   = 8,
    localparam int SRC_W        = $clog2(N_SRC)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [N_SRC-1:0][KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] s_data_in,
    input  logic [N_SRC-1:0][KEEP_WIDTH-1:0]                   s_keep_in,
    input  logic [N_SRC-1:0]                                   s_last_in,
    input  logic [N_SRC-1:0]                                   s_valid_in,
    output logic [N_SRC-1:0]                                   s_ready_out,
    output logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]            m_data_out,
    output logic [KEEP_WIDTH-1:0]                              m_keep_out,
    output logic                                               m_last_out,
    output logic                                               m_valid_out,
    input  logic                                               m_ready_in,
    output logic [SRC_W-1:0]                                   m_src_out,
    output logic                                               busy_out
);

    localparam int  DATA_W   = KEEP_WIDTH * T_DATA_WIDTH;
    localparam logic ST_IDLE  = ARB_IDLE;
    localparam logic ST_GRANT = ARB_GRANT;

    logic             r_state;
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W-1:0] r_grant;

    logic [SRC_W-1:0]      w_pick;
    logic [SRC_W-1:0]      w_pick_next;
    logic                  w_any_req;
    logic                  w_slot_free;
    logic                  w_accept;
    logic                  w_load;
    logic [DATA_W-1:0]     w_beat_data;
    logic [KEEP_WIDTH-1:0] w_beat_keep;
    logic                  w_beat_last;
    logic [DATA_W-1:0]     w_out_data;

    assign w_any_req   = |s_valid_in;
    assign w_pick      = SRC_W'(rr_pick(32'(s_valid_in), int'(r_rr_ptr), N_SRC));
    assign w_pick_next = (w_pick == SRC_W'(N_SRC - 1)) ? '0 : w_pick + SRC_W'(1);

    assign w_beat_data = s_data_in[r_grant];
    assign w_beat_keep = s_keep_in[r_grant];
    assign w_beat_last = s_last_in[r_grant];

    assign w_accept = (r_state == ST_GRANT) && s_valid_in[r_grant] && w_slot_free;

    // An empty non-last beat carries nothing for the rescaler, so it is
    // consumed without loading the register. An empty last beat still goes
    // through so the packet boundary reaches downstream.
    assign w_load = w_accept && ((|w_beat_keep) || w_beat_last);

    always_comb begin
        s_ready_out = '0;
        if (r_state == ST_GRANT) begin
            s_ready_out[r_grant] = w_slot_free;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant  <= w_pick;
                        r_rr_ptr <= w_pick_next;
                        r_state  <= ST_GRANT;
                    end
                end
                default: begin
                    if (w_accept && w_beat_last) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy_out = (r_state == ST_GRANT);

    stream_reg_slice #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_WIDTH),
        .USER_W (SRC_W)
    ) u_out_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s_tdata  (w_beat_data),
        .i_s_tkeep  (w_beat_keep),
        .i_s_tlast  (w_beat_last),
        .i_s_tuser  (r_grant),
        .i_s_tvalid (w_load),
        .o_s_tready (w_slot_free),
        .o_m_tdata  (w_out_data),
        .o_m_tkeep  (m_keep_out),
        .o_m_tlast  (m_last_out),
        .o_m_tuser  (m_src_out),
        .o_m_tvalid (m_valid_out),
        .i_m_tready (m_ready_in)
    );

    assign m_data_out = w_out_data;

endmodule
